// File: rtl/falling_tile_engine.sv
// Multi-lane falling tile mover: on each frame tick, every active tile moves down one row.
// Each move is a serial sweep of vga_adapter pixel writes: erase the top row, then draw the new bottom row.
module falling_tile_engine #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned TILE_W     = 30,
  parameter int unsigned TILE_H     = 30,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned LANE_X0    = 20,
  parameter int unsigned LANE_PITCH = 32,
  parameter int unsigned TICK_DIV   = 833333
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 spawn_valid,
  input  logic [2:0]           spawn_lane,
  input  logic [2:0]           spawn_colour,
  output logic                 spawn_ready,
  output logic                 plot,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 busy,
  output logic [NUM_LANES-1:0] tile_active,
  output logic                 miss,
  output logic                 overrun
);

  localparam int unsigned LANE_W   = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned LANES_P2 = 1 << LANE_W;
  localparam int unsigned DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned POS_W    = 9;
  localparam int unsigned COL_W    = 5;

  localparam logic [DIV_W-1:0]  DIV_RELOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0]  TILE_H_P   = POS_W'(TILE_H);
  localparam logic [POS_W-1:0]  SCREEN_H_P = POS_W'(SCREEN_H);
  localparam logic [POS_W-1:0]  RETIRE_POS = POS_W'(SCREEN_H + TILE_H);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(TILE_W - 1);
  localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(NUM_LANES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, ERASE, DRAW, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                pending_q, pending_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [LANES_P2-1:0] active_q, active_d;
  logic [2:0]          colr_q [LANES_P2];
  logic [2:0]          colr_d [LANES_P2];
  logic [POS_W-1:0]    pos_q  [LANES_P2];
  logic [POS_W-1:0]    pos_d  [LANES_P2];
  logic                plot_q, plot_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [2:0]          colour_q, colour_d;
  logic                busy_q, busy_d;
  logic                miss_q, miss_d;
  logic                overrun_q, overrun_d;

  logic                tick_c;
  logic                spawn_lane_ok_c;
  logic [LANE_W-1:0]   spawn_idx_c;
  logic [POS_W-1:0]    cur_pos_c;

  assign tick_c          = enable && (div_q == '0);
  assign spawn_lane_ok_c = 32'(spawn_lane) < NUM_LANES;
  assign spawn_idx_c     = LANE_W'(spawn_lane);
  assign cur_pos_c       = pos_q[lane_q];

  assign spawn_ready = (state_q == IDLE) && !pending_q && !tick_c &&
                       spawn_lane_ok_c && !active_q[spawn_idx_c];

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pending_d = pending_q;
    lane_d    = lane_q;
    col_d     = col_q;
    active_d  = active_q;
    colr_d    = colr_q;
    pos_d     = pos_q;
    plot_d    = 1'b0;
    x_d       = x_q;
    y_d       = y_q;
    colour_d  = colour_q;
    miss_d    = 1'b0;
    overrun_d = 1'b0;

    if (enable) begin
      div_d = tick_c ? DIV_RELOAD : div_q - DIV_W'(1);
    end

    // A tick arriving mid-sweep is parked; a second one before the sweep ends is lost.
    if (state_q != IDLE && tick_c) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    if (spawn_valid && spawn_ready) begin
      active_d[spawn_idx_c] = 1'b1;
      colr_d[spawn_idx_c]   = spawn_colour;
      pos_d[spawn_idx_c]    = '0;
    end

    case (state_q)
      IDLE: begin
        if (pending_q || tick_c) begin
          state_d   = SCAN;
          lane_d    = '0;
          pending_d = pending_q && tick_c;
        end
      end
      SCAN: begin
        col_d = '0;
        if (!active_q[lane_q]) begin
          state_d = (lane_q == LAST_LANE) ? IDLE : SCAN;
          lane_d  = (lane_q == LAST_LANE) ? lane_q : lane_q + LANE_W'(1);
        end else if (cur_pos_c >= TILE_H_P) begin
          state_d = ERASE;
        end else if (cur_pos_c < SCREEN_H_P) begin
          state_d = DRAW;
        end else begin
          state_d = UPDATE;
        end
      end
      ERASE: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = (cur_pos_c < SCREEN_H_P) ? DRAW : UPDATE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      DRAW: begin
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = UPDATE;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      UPDATE: begin
        pos_d[lane_q] = cur_pos_c + POS_W'(1);
        if (cur_pos_c + POS_W'(1) == RETIRE_POS) begin
          active_d[lane_q] = 1'b0;
          miss_d           = 1'b1;
        end
        state_d = (lane_q == LAST_LANE) ? IDLE : SCAN;
        lane_d  = (lane_q == LAST_LANE) ? lane_q : lane_q + LANE_W'(1);
      end
      default: state_d = IDLE;
    endcase

    // Pixel outputs follow the state being entered, so each pixel state cycle shows its own column.
    if (state_d == ERASE) begin
      plot_d   = 1'b1;
      y_d      = 7'(cur_pos_c - TILE_H_P);
      colour_d = 3'd0;
    end else if (state_d == DRAW) begin
      plot_d   = 1'b1;
      y_d      = 7'(cur_pos_c);
      colour_d = colr_q[lane_q];
    end
    if (plot_d) begin
      x_d = 8'(LANE_X0 + LANE_PITCH * 32'(lane_q) + 32'(col_d));
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      div_q     <= DIV_RELOAD;
      pending_q <= 1'b0;
      lane_q    <= '0;
      col_q     <= '0;
      active_q  <= '0;
      for (int i = 0; i < int'(LANES_P2); i++) begin
        colr_q[i] <= '0;
        pos_q[i]  <= '0;
      end
      plot_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
      busy_q    <= 1'b0;
      miss_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pending_q <= pending_d;
      lane_q    <= lane_d;
      col_q     <= col_d;
      active_q  <= active_d;
      colr_q    <= colr_d;
      pos_q     <= pos_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      busy_q    <= busy_d;
      miss_q    <= miss_d;
      overrun_q <= overrun_d;
    end
  end

  assign plot        = plot_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign busy        = busy_q;
  assign tile_active = active_q[NUM_LANES-1:0];
  assign miss        = miss_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_falling_tile_engine.sv
// Directed bench for falling_tile_engine: a small 2-lane screen plus a fast-tick copy for overrun and reset.
module tb_falling_tile_engine;

  logic       clk;
  logic       resetn, enable, spawn_valid;
  logic [2:0] spawn_lane, spawn_colour;
  logic       spawn_ready, plot, busy, miss, overrun;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic [1:0] tile_active;

  logic       f_resetn, f_enable, f_spawn_valid;
  logic [2:0] f_spawn_lane, f_spawn_colour;
  logic       f_spawn_ready, f_plot, f_busy, f_miss, f_overrun;
  logic [7:0] f_x;
  logic [6:0] f_y;
  logic [2:0] f_colour;
  logic [1:0] f_tile_active;

  falling_tile_engine #(
    .NUM_LANES(2), .TILE_W(4), .TILE_H(3), .SCREEN_H(8),
    .LANE_X0(20), .LANE_PITCH(10), .TICK_DIV(40)
  ) u_dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_colour(spawn_colour),
    .spawn_ready(spawn_ready), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .tile_active(tile_active), .miss(miss), .overrun(overrun)
  );

  falling_tile_engine #(
    .NUM_LANES(2), .TILE_W(4), .TILE_H(3), .SCREEN_H(8),
    .LANE_X0(20), .LANE_PITCH(10), .TICK_DIV(4)
  ) u_fast (
    .clk(clk), .resetn(f_resetn), .enable(f_enable),
    .spawn_valid(f_spawn_valid), .spawn_lane(f_spawn_lane), .spawn_colour(f_spawn_colour),
    .spawn_ready(f_spawn_ready), .plot(f_plot), .x(f_x), .y(f_y), .colour(f_colour),
    .busy(f_busy), .tile_active(f_tile_active), .miss(f_miss), .overrun(f_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [17:0] pq[$];
  int          miss_cnt = 0;
  int          ovr_cnt  = 0;
  logic [1:0]  miss_act = 2'b11;

  always @(negedge clk) begin
    if (plot) pq.push_back({x, y, colour});
    if (miss) begin
      miss_cnt++;
      miss_act = tile_active;
    end
    if (overrun) ovr_cnt++;
  end

  function automatic logic [17:0] pix(input int px, input int py, input int pc);
    return {8'(px), 7'(py), 3'(pc)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the next sweep, returning busy length and first-plot offset from busy rising.
  task automatic run_sweep(input string tag, output int bcyc, output int lat);
    int n;
    n = 0;
    bcyc = 0;
    lat = -1;
    pq.delete();
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, 32'(busy), 32'd1);
    while (busy && bcyc < 200) begin
      if (plot && lat < 0) lat = bcyc;
      @(negedge clk);
      bcyc++;
    end
    check({tag, "_end"}, 32'(busy), 32'd0);
  endtask

  task automatic check_row(input string tag, input int off, input int bx, input int py, input int pc);
    for (int i = 0; i < 4; i++) begin
      check(tag, 32'(pq[off + i]), 32'(pix(bx + i, py, pc)));
    end
  endtask

  initial begin
    int  bc, lat, n;
    bit  seen;

    resetn = 1'b0; enable = 1'b0; spawn_valid = 1'b0; spawn_lane = 3'd0; spawn_colour = 3'd0;
    f_resetn = 1'b0; f_enable = 1'b0; f_spawn_valid = 1'b0; f_spawn_lane = 3'd0; f_spawn_colour = 3'd0;
    repeat (3) @(negedge clk);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_active", 32'(tile_active), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    resetn = 1'b1;
    f_resetn = 1'b1;
    @(negedge clk);
    check("post_rst_plot", 32'(plot), 32'd0);

    // Spawn readiness and acceptance
    spawn_lane = 3'd3;
    #1 check("ready_lane3", 32'(spawn_ready), 32'd0);
    spawn_lane = 3'd0;
    #1 check("ready_lane0_idle", 32'(spawn_ready), 32'd1);
    spawn_lane = 3'd1; spawn_colour = 3'd5; spawn_valid = 1'b1;
    #1 check("ready_lane1", 32'(spawn_ready), 32'd1);
    @(negedge clk);
    spawn_valid = 1'b0;
    check("active_after_spawn", 32'(tile_active), 32'b10);
    spawn_colour = 3'd2; spawn_valid = 1'b1;
    #1 check("ready_occupied", 32'(spawn_ready), 32'd0);
    @(negedge clk);
    spawn_valid = 1'b0;
    check("active_unchanged", 32'(tile_active), 32'b10);
    check("no_plot_at_spawn", 32'(pq.size()), 32'd0);

    // Tick 1: draw row 0 of lane 1
    enable = 1'b1;
    run_sweep("t1", bc, lat);
    check("t1_busy_len", 32'(bc), 32'd7);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_count", 32'(pq.size()), 32'd4);
    check_row("t1_draw", 0, 30, 0, 5);

    // Tick 2: spawn attempted while busy is refused
    pq.delete();
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t2_start", 32'(busy), 32'd1);
    spawn_lane = 3'd0; spawn_colour = 3'd1; spawn_valid = 1'b1;
    #1 check("ready_busy", 32'(spawn_ready), 32'd0);
    @(negedge clk);
    spawn_valid = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t2_active", 32'(tile_active), 32'b10);
    check("t2_count", 32'(pq.size()), 32'd4);
    check("t2_pix", 32'(pq[0]), 32'(pix(30, 1, 5)));

    run_sweep("t3", bc, lat);
    check("t3_count", 32'(pq.size()), 32'd4);
    check("t3_pix", 32'(pq[0]), 32'(pix(30, 2, 5)));

    // Tick 4: erase row 0 strictly before drawing row 3
    run_sweep("t4", bc, lat);
    check("t4_busy_len", 32'(bc), 32'd11);
    check("t4_count", 32'(pq.size()), 32'd8);
    check_row("t4_erase", 0, 30, 0, 0);
    check_row("t4_draw", 4, 30, 3, 5);

    for (int t = 5; t <= 8; t++) begin
      run_sweep("tmid", bc, lat);
      check("tmid_count", 32'(pq.size()), 32'd8);
      check("tmid_erase", 32'(pq[0]), 32'(pix(30, t - 4, 0)));
      check("tmid_draw", 32'(pq[4]), 32'(pix(30, t - 1, 5)));
    end

    // Ticks 9..11: tile slides off the bottom, erase only
    for (int t = 9; t <= 10; t++) begin
      run_sweep("tlow", bc, lat);
      check("tlow_busy_len", 32'(bc), 32'd7);
      check("tlow_count", 32'(pq.size()), 32'd4);
      check_row("tlow_erase", 0, 30, t - 4, 0);
    end
    check("no_early_miss", 32'(miss_cnt), 32'd0);
    run_sweep("t11", bc, lat);
    check("t11_count", 32'(pq.size()), 32'd4);
    check_row("t11_erase", 0, 30, 7, 0);
    repeat (3) @(negedge clk);
    check("miss_once", 32'(miss_cnt), 32'd1);
    check("miss_with_retire", 32'(miss_act), 32'd0);
    check("retired_active", 32'(tile_active), 32'd0);

    // Two active lanes: lane 0 sweeps before lane 1
    spawn_lane = 3'd0; spawn_colour = 3'd2; spawn_valid = 1'b1;
    #1 check("ready_two_a", 32'(spawn_ready), 32'd1);
    @(negedge clk);
    spawn_lane = 3'd1; spawn_colour = 3'd7;
    #1 check("ready_two_b", 32'(spawn_ready), 32'd1);
    @(negedge clk);
    spawn_valid = 1'b0;
    check("two_active", 32'(tile_active), 32'b11);
    run_sweep("two", bc, lat);
    check("two_busy_len", 32'(bc), 32'd12);
    check("two_latency", 32'(lat), 32'd1);
    check("two_count", 32'(pq.size()), 32'd8);
    check_row("two_lane0", 0, 20, 0, 2);
    check_row("two_lane1", 4, 30, 0, 7);
    check("slow_no_overrun", 32'(ovr_cnt), 32'd0);
    enable = 1'b0;

    // Fast tick: sweeps outlast the tick period, so ticks get dropped
    f_spawn_lane = 3'd0; f_spawn_colour = 3'd3; f_spawn_valid = 1'b1;
    #1 check("f_ready_a", 32'(f_spawn_ready), 32'd1);
    @(negedge clk);
    f_spawn_lane = 3'd1; f_spawn_colour = 3'd6;
    #1 check("f_ready_b", 32'(f_spawn_ready), 32'd1);
    @(negedge clk);
    f_spawn_valid = 1'b0;
    check("f_active", 32'(f_tile_active), 32'b11);
    f_enable = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (f_overrun) seen = 1'b1;
      n++;
    end
    check("f_overrun", 32'(seen), 32'd1);

    // Reset in the middle of an erase row
    seen = 1'b0;
    n = 0;
    while (!seen && n < 400) begin
      @(negedge clk);
      if (f_plot && f_colour == 3'd0) seen = 1'b1;
      n++;
    end
    check("f_erase_seen", 32'(seen), 32'd1);
    f_resetn = 1'b0;
    @(negedge clk);
    check("f_rst_plot", 32'(f_plot), 32'd0);
    check("f_rst_active", 32'(f_tile_active), 32'd0);
    check("f_rst_busy", 32'(f_busy), 32'd0);
    f_resetn = 1'b1;
    @(negedge clk);
    check("f_post_rst_plot", 32'(f_plot), 32'd0);
    f_enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
